uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_rx_oversampled_if.sv | 22 ++
 rtl/uart_rx_oversampled.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_oversampled_if.sv
// Signal bundle between a serial-line/config driver and the oversampled UART receiver.
interface uart_rx_oversampled_if;
    logic       s_tick;
    logic       rx;
    logic       data_bits;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output s_tick, rx, data_bits, parity_mode, stop_bits,
        input  dout, rx_done_tick, parity_err, frame_err
    );

    modport slave (
        input  s_tick, rx, data_bits, parity_mode, stop_bits,
        output dout, rx_done_tick, parity_err, frame_err
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 7/8 data bits, optional even/odd parity, 1/2 stop bits,
// centre-of-bit sampling driven by an external OVS x baud tick.
module uart_rx_oversampled #(
    parameter int OVS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_oversampled_if.slave  bus
);
    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TOP     = TW'(OVS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic          rx_meta_q, rx_s_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          db_q, db_d;
    logic [1:0]    pm_q, pm_d;
    logic          sb_q, sb_d;
    logic          perr_pend_q, perr_pend_d;
    logic          ferr_pend_q, ferr_pend_d;
    logic          brk_q, brk_d;
    logic [7:0]    dout_q, dout_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          done_q, done_d;

    logic          par_en, par_exp, ferr_now;
    logic [2:0]    last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shreg_q     <= '0;
            db_q        <= 1'b1;
            pm_q        <= 2'b00;
            sb_q        <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            brk_q       <= 1'b0;
            dout_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shreg_q     <= shreg_d;
            db_q        <= db_d;
            pm_q        <= pm_d;
            sb_q        <= sb_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            brk_q       <= brk_d;
            dout_q      <= dout_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            done_q      <= done_d;
        end
    end

    // shreg is cleared at frame start, so in 7-bit mode bit 0 is 0 and ^shreg_q covers only data
    assign par_en   = (pm_q == 2'b01) || (pm_q == 2'b10);
    assign par_exp  = (pm_q == 2'b10) ? ~(^shreg_q) : ^shreg_q;
    assign last_bit = db_q ? 3'd7 : 3'd6;
    assign ferr_now = ferr_pend_q | ~rx_s_q;

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shreg_d     = shreg_q;
        db_d        = db_q;
        pm_d        = pm_q;
        sb_d        = sb_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        brk_d       = brk_q;
        dout_d      = dout_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        done_d      = 1'b0;

        if (bus.s_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (brk_q) begin
                        if (rx_s_q) brk_d = 1'b0;
                    end else if (!rx_s_q) begin
                        state_d     = S_START;
                        tick_d      = '0;
                        db_d        = bus.data_bits;
                        pm_d        = bus.parity_mode;
                        sb_d        = bus.stop_bits;
                        shreg_d     = '0;
                        perr_pend_d = 1'b0;
                        ferr_pend_d = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_q == TOP) begin
                        tick_d  = '0;
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        if (bit_q == last_bit) begin
                            bit_d   = '0;
                            stop_d  = 1'b0;
                            state_d = par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_q == TOP) begin
                        tick_d      = '0;
                        stop_d      = 1'b0;
                        perr_pend_d = (rx_s_q != par_exp);
                        state_d     = S_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_q == TOP) begin
                        tick_d      = '0;
                        ferr_pend_d = ferr_now;
                        if (stop_q == sb_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            dout_d  = db_q ? shreg_q : {1'b0, shreg_q[7:1]};
                            perr_d  = par_en & perr_pend_q;
                            ferr_d  = ferr_now;
                            // a line held low through the stop bit is a break, not a new start
                            brk_d   = ferr_now & ~rx_s_q;
                        end else begin
                            stop_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.parity_err   = perr_q;
    assign bus.frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames push expected results, a monitor checks each done pulse.
module tb_uart_rx_oversampled;
    localparam int OVS = 16;
    localparam int DIV = 4;
    localparam int BIT = OVS * DIV;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   div_cnt = 0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    uart_rx_oversampled_if bus();

    uart_rx_oversampled #(.OVS(OVS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        bus.s_tick = (div_cnt == DIV - 1);
        div_cnt = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            chk("done_width_prev", {7'd0, prev_done}, 8'h00);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=pulse dout=%h expected=no pulse", bus.dout);
            end else begin
                mon_e = q.pop_front();
                chk("dout", bus.dout, mon_e.d);
                chk("parity_err", {7'd0, bus.parity_err}, {7'd0, mon_e.pe});
                chk("frame_err", {7'd0, bus.frame_err}, {7'd0, mon_e.fe});
            end
        end
        prev_done = bus.rx_done_tick;
    end

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        bus.rx = 1'b1;
        repeat (nbits * BIT) @(negedge clk);
    endtask

    task automatic cfg(input logic db, input logic [1:0] pm, input logic sb);
        bus.data_bits   = db;
        bus.parity_mode = pm;
        bus.stop_bits   = sb;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic par, input int nstop, input logic last_stop,
                              input logic scramble);
        logic       save_db;
        logic [1:0] save_pm;
        logic       save_sb;
        save_db = bus.data_bits;
        save_pm = bus.parity_mode;
        save_sb = bus.stop_bits;
        drive_bit(1'b0);
        if (scramble) cfg(~save_db, 2'b00, ~save_sb);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par);
        for (int i = 0; i < nstop; i++) drive_bit((i == nstop - 1) ? last_stop : 1'b1);
        cfg(save_db, save_pm, save_sb);
    endtask

    initial begin
        rst = 1'b1;
        bus.rx = 1'b1;
        cfg(1'b1, 2'b00, 1'b0);
        repeat (5) @(negedge clk);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_done", {7'd0, bus.rx_done_tick}, 8'h00);
        chk("rst_perr", {7'd0, bus.parity_err}, 8'h00);
        chk("rst_ferr", {7'd0, bus.frame_err}, 8'h00);
        rst = 1'b0;
        idle(2);

        // 8N1 0xA5
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        idle(1);

        // 7E1 0x41 (two ones -> even parity bit 0); config scrambled mid-frame
        cfg(1'b0, 2'b01, 1'b0);
        push(8'h41, 1'b1, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        idle(1);
        push(8'h41, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        idle(1);

        // 8O2 0x00, odd parity bit 1 correct, second stop low, then line held low (break)
        cfg(1'b1, 2'b10, 1'b1);
        push(8'h00, 1'b0, 1'b1);
        send_frame(8'h00, 8, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        idle(2);

        // 4-tick glitch while idle
        cfg(1'b1, 2'b00, 1'b0);
        bus.rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        idle(2);
        chk("glitch_dout", bus.dout, 8'h00);
        chk("glitch_perr", {7'd0, bus.parity_err}, 8'h00);
        chk("glitch_ferr", {7'd0, bus.frame_err}, 8'h01);

        // reset in the middle of 0x3C data bits
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_dout", bus.dout, 8'h00);
        chk("midrst_perr", {7'd0, bus.parity_err}, 8'h00);
        chk("midrst_ferr", {7'd0, bus.frame_err}, 8'h00);
        rst = 1'b0;
        idle(2);
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        idle(1);

        // back-to-back 8N1
        push(8'h12, 1'b0, 1'b0);
        push(8'h34, 1'b0, 1'b0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        idle(2);

        chk("pending_expected", 8'(q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
